// File: rtl/vram_port_arbiter_if.sv
// vram_port_arbiter_if: video/CPU requester ports and the RAM-side port of the VRAM arbiter
interface vram_port_arbiter_if #(
  parameter int ADDR_W    = 15,
  parameter int NB_COL    = 4,
  parameter int COL_WIDTH = 8
);
  localparam int DATA_W = NB_COL * COL_WIDTH;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [NB_COL-1:0] cpu_be;
  logic              cpu_ack;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [NB_COL-1:0] ram_we;
  logic [DATA_W-1:0] ram_dout;
  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_addr, cpu_wdata, cpu_be, ram_dout,
    output vid_ack, vid_rvalid, vid_rdata, cpu_ack, cpu_rvalid, cpu_rdata,
           ram_addr, ram_din, ram_we
  );
  modport master (
    output vid_req, vid_addr, cpu_req, cpu_addr, cpu_wdata, cpu_be, ram_dout,
    input  vid_ack, vid_rvalid, vid_rdata, cpu_ack, cpu_rvalid, cpu_rdata,
           ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares a single-port byte-write VRAM between a video reader and a CPU
module vram_port_arbiter #(
  parameter int ADDR_W      = 15,
  parameter int NB_COL      = 4,
  parameter int COL_WIDTH   = 8,
  parameter int RAM_LATENCY = 2,
  parameter int MAX_WAIT    = 7
) (
  input logic clk,
  input logic rst,
  vram_port_arbiter_if.slave bus_io
);
  localparam int DATA_W = NB_COL * COL_WIDTH;
  localparam int WW     = $clog2(MAX_WAIT + 1);
  localparam int TD     = RAM_LATENCY + 1;
  logic [WW-1:0]     wait_q, wait_d;
  logic [TD-1:0]     tv_q, tv_d, to_q, to_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [NB_COL-1:0] we_q, we_d;
  logic              starve, cpu_ack, vid_ack, cpu_rd;
  assign starve  = wait_q == WW'(MAX_WAIT);
  assign cpu_ack = !rst && bus_io.cpu_req && (!bus_io.vid_req || starve);
  assign vid_ack = !rst && bus_io.vid_req && !cpu_ack;
  assign cpu_rd  = cpu_ack && bus_io.cpu_be == '0;
  // tag pipeline: tv = read in flight, to = owner (1 = CPU); stage TD-1 lines up with ram_dout
  always_comb begin
    wait_d = (cpu_ack || !bus_io.cpu_req) ? '0 : starve ? wait_q : wait_q + 1'b1;
    addr_d = cpu_ack ? bus_io.cpu_addr : vid_ack ? bus_io.vid_addr : addr_q;
    din_d  = cpu_ack ? bus_io.cpu_wdata : din_q;
    we_d   = cpu_ack ? bus_io.cpu_be : '0;
    tv_d   = {tv_q[TD-2:0], vid_ack || cpu_rd};
    to_d   = {to_q[TD-2:0], cpu_ack};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= '0;
      tv_q   <= '0;
      to_q   <= '0;
      addr_q <= '0;
      din_q  <= '0;
      we_q   <= '0;
    end else begin
      wait_q <= wait_d;
      tv_q   <= tv_d;
      to_q   <= to_d;
      addr_q <= addr_d;
      din_q  <= din_d;
      we_q   <= we_d;
    end
  end
  assign bus_io.cpu_ack    = cpu_ack;
  assign bus_io.vid_ack    = vid_ack;
  assign bus_io.ram_addr   = addr_q;
  assign bus_io.ram_din    = din_q;
  assign bus_io.ram_we     = we_q;
  assign bus_io.vid_rvalid = tv_q[TD-1] && !to_q[TD-1];
  assign bus_io.cpu_rvalid = tv_q[TD-1] && to_q[TD-1];
  assign bus_io.vid_rdata  = bus_io.ram_dout;
  assign bus_io.cpu_rdata  = bus_io.ram_dout;
endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb_vram_port_arbiter: randomized bench with a transaction-level reference model of the arbiter
module tb_vram_port_arbiter;
  localparam int AW = 15, NB = 4, CW = 8, DW = 32, MW = 7, LAT = 2;
  typedef struct {int due; logic [DW-1:0] d;} ret_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  vram_port_arbiter_if #(.ADDR_W(AW), .NB_COL(NB), .COL_WIDTH(CW)) a_if ();
  vram_port_arbiter_if #(.ADDR_W(AW), .NB_COL(NB), .COL_WIDTH(CW)) b_if ();
  vram_port_arbiter #(.ADDR_W(AW), .NB_COL(NB), .COL_WIDTH(CW), .RAM_LATENCY(LAT), .MAX_WAIT(MW))
    dut_a (.clk(clk), .rst(rst), .bus_io(a_if.slave));
  vram_port_arbiter #(.ADDR_W(AW), .NB_COL(NB), .COL_WIDTH(CW), .RAM_LATENCY(1), .MAX_WAIT(MW))
    dut_b (.clk(clk), .rst(rst), .bus_io(b_if.slave));
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] mdl [0:(1<<AW)-1];
  logic [DW-1:0] pipe_a, dout_a, dout_b;
  // write-first byte-lane RAM; dut_a sees a 2-cycle output-registered RAM, dut_b a 1-cycle one
  always @(posedge clk) begin : ram_model
    logic [DW-1:0] w;
    w = ram[a_if.ram_addr];
    for (int i = 0; i < NB; i++) if (a_if.ram_we[i]) w[i*CW +: CW] = a_if.ram_din[i*CW +: CW];
    ram[a_if.ram_addr] = w;
    pipe_a <= w;
    dout_a <= pipe_a;
    dout_b <= ram[b_if.ram_addr];
  end
  assign a_if.ram_dout = dout_a;
  assign b_if.ram_dout = dout_b;
  int vectors = 0, errs = 0, cyc = 0, mw = 0;
  ret_t vq[$], cq[$];
  logic [NB-1:0] exp_we = '0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_din = '0;
  bit vp = 0, cp = 0, cack_seen = 0;
  logic [AW-1:0] va = '0, ca = '0;
  logic [DW-1:0] cd = '0;
  logic [NB-1:0] cb = '0;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask
  task automatic tick();
    bit ec, ev, req;
    a_if.vid_req = vp; a_if.vid_addr = va;
    a_if.cpu_req = cp; a_if.cpu_addr = ca; a_if.cpu_wdata = cd; a_if.cpu_be = cb;
    @(negedge clk);
    if (rst) begin vq.delete(); cq.delete(); mw = 0; exp_we = '0; exp_addr = '0; exp_din = '0; end
    req = cp;
    ec = !rst && cp && (!vp || mw == MW);
    ev = !rst && vp && !ec;
    check("cpu_ack", a_if.cpu_ack, ec);
    check("vid_ack", a_if.vid_ack, ev);
    check("ram_we", a_if.ram_we, exp_we);
    check("ram_addr", a_if.ram_addr, exp_addr);
    if (exp_we != 0) check("ram_din", a_if.ram_din, exp_din);
    if (vq.size() > 0 && vq[0].due == cyc) begin
      check("vid_rvalid", a_if.vid_rvalid, 1);
      check("vid_rdata", a_if.vid_rdata, vq[0].d);
      void'(vq.pop_front());
    end else check("vid_rvalid", a_if.vid_rvalid, 0);
    if (cq.size() > 0 && cq[0].due == cyc) begin
      check("cpu_rvalid", a_if.cpu_rvalid, 1);
      check("cpu_rdata", a_if.cpu_rdata, cq[0].d);
      void'(cq.pop_front());
    end else check("cpu_rvalid", a_if.cpu_rvalid, 0);
    cack_seen = a_if.cpu_ack;
    exp_we = '0;
    if (ec) begin
      exp_addr = ca; exp_din = cd; exp_we = cb;
      if (cb == 0) cq.push_back('{cyc + 1 + LAT, mdl[ca]});
      else for (int b = 0; b < NB; b++) if (cb[b]) mdl[ca][b*CW +: CW] = cd[b*CW +: CW];
      cp = 0;
    end else if (ev) begin
      exp_addr = va;
      vq.push_back('{cyc + 1 + LAT, mdl[va]});
      vp = 0;
    end
    mw = (rst || !req || ec) ? 0 : (mw < MW ? mw + 1 : MW);
    @(posedge clk); #1;
    cyc++;
  endtask
  task automatic cpu(logic [AW-1:0] a, logic [DW-1:0] d, logic [NB-1:0] be);
    cp = 1; ca = a; cd = d; cb = be;
  endtask
  initial begin
    int n;
    bit done;
    for (int i = 0; i < (1 << AW); i++) begin ram[i] = '0; mdl[i] = '0; end
    ram[16] = 32'hDEADBEEF; mdl[16] = 32'hDEADBEEF;
    ram[32] = 32'hAAAAAAAA; mdl[32] = 32'hAAAAAAAA;
    for (int i = 0; i < 4; i++) begin ram[i] = 32'h1000 + i; mdl[i] = 32'h1000 + i; end
    b_if.vid_req = 0; b_if.vid_addr = '0; b_if.cpu_req = 0;
    b_if.cpu_addr = '0; b_if.cpu_wdata = '0; b_if.cpu_be = '0;
    cpu(15'h10, 0, 0);
    repeat (2) tick();
    rst = 0; cp = 0;
    tick();
    cpu(15'h10, 0, 0); tick();
    repeat (4) tick();
    cpu(15'h20, 32'h11223344, 4'b0101); tick();
    cpu(15'h20, 0, 0); tick();
    repeat (4) tick();
    cpu(15'h30, 0, 0);
    n = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      vp = 1; va = AW'(i);
      tick();
      if (cack_seen) done = 1; else n++;
    end
    check("starve_wait", n, MW);
    vp = 1; va = 15'h5; tick();
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin vp = 1; va = AW'(i); tick(); end
    repeat (4) tick();
    cpu(15'h10, 0, 0); tick();
    cpu(15'h20, 0, 0); tick();
    rst = 1; tick();
    rst = 0;
    repeat (5) tick();
    cpu(15'h20, 0, 0); tick();
    repeat (4) tick();
    for (int i = 0; i < 600; i++) begin
      if (!vp && (i >= 300 || $urandom_range(0, 2) == 0)) begin
        vp = 1; va = AW'($urandom_range(32'h40, 32'h4F));
      end
      if (!cp && $urandom_range(0, 1) == 0)
        cpu(AW'($urandom_range(32'h40, 32'h4F)), $urandom,
            $urandom_range(0, 1) ? '0 : NB'($urandom));
      tick();
    end
    vp = 0; cp = 0;
    repeat (6) tick();
    b_if.cpu_req = 1; b_if.cpu_addr = 15'h10;
    @(negedge clk);
    check("b_cpu_ack", b_if.cpu_ack, 1);
    @(posedge clk); #1;
    b_if.cpu_req = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("b_cpu_rvalid", b_if.cpu_rvalid, k == 2);
      check("b_vid_rvalid", b_if.vid_rvalid, 0);
      if (k == 2) check("b_cpu_rdata", b_if.cpu_rdata, 32'hDEADBEEF);
      @(posedge clk); #1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
